// File: rtl/half_period_meter_pkg.sv
// Shared types for the half-period meter: FSM state encoding.
package half_period_meter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_e;

endpackage

// File: rtl/half_period_meter_sync_edge_det.sv
// Synchronizes an async level and flags either-polarity edges; edge_o is high
// SYNC_STAGES cycles after the input moves (consumer registers it), no backpressure.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   dly_q;
  logic                   dly_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  // Both flops are clean register outputs, so the XOR cannot glitch on metastability.
  assign edge_o = sync_q[SYNC_STAGES-1] ^ dly_q;

endmodule

// File: rtl/half_period_meter.sv
// Measures the half-period of an async square wave in divider-load units (N, f=fclk/2(N+1)).
// Result lands one cycle after the synchronized edge; free-running, no backpressure.
module half_period_meter
  import half_period_meter_pkg::*;
#(
  parameter int WIDTH       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [WIDTH-1:0] measure_out,
  output logic             valid,
  output logic             locked,
  output logic             overflow
);

  logic             edge_det;
  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] meas_q;
  logic [WIDTH-1:0] meas_d;
  logic             valid_q;
  logic             valid_d;
  logic             locked_q;
  logic             locked_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             have_meas_q;
  logic             have_meas_d;
  logic             cnt_max;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .clk_i  (clk_in),
    .rst_i  (rst),
    .async_i(sig_in),
    .edge_o (edge_det)
  );

  assign cnt_max = (cnt_q == {WIDTH{1'b1}});

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (edge_det) begin
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (!edge_det && cnt_max) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // An edge always wins over the counter saturating in the same cycle.
  always_comb begin
    cnt_d       = cnt_q;
    meas_d      = meas_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    ovf_d       = ovf_q;
    have_meas_d = have_meas_q;
    case (state_q)
      ST_IDLE: begin
        if (edge_det) begin
          cnt_d = '0;
        end
      end
      ST_MEASURE: begin
        if (edge_det) begin
          meas_d      = cnt_q;
          valid_d     = 1'b1;
          ovf_d       = 1'b0;
          cnt_d       = '0;
          locked_d    = have_meas_q && (cnt_q == meas_q);
          have_meas_d = 1'b1;
        end else if (cnt_max) begin
          ovf_d       = 1'b1;
          locked_d    = 1'b0;
          have_meas_d = 1'b0;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q       <= '0;
      meas_q      <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      ovf_q       <= 1'b0;
      have_meas_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      meas_q      <= meas_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      ovf_q       <= ovf_d;
      have_meas_q <= have_meas_d;
    end
  end

  assign measure_out = meas_q;
  assign valid       = valid_q;
  assign locked      = locked_q;
  assign overflow    = ovf_q;

endmodule

// File: doc/half_period_meter.md
HALF_PERIOD_METER -- requirements
Module: half_period_meter

Interface
REQ-001 Parameter WIDTH, default 24: width of the measured count, matching the divider load width.
REQ-002 Parameter SYNC_STAGES, default 2: number of flip-flop synchronizer stages on sig_in (minimum 2).
REQ-003 clk_in  input  1: the only clock; all logic on its rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 sig_in  input  1: square wave to measure; asynchronous to clk_in.
REQ-006 measure_out  output  WIDTH: last measured half-period N, in divider-load units, where f_sig = f_clk_in/2(N+1).
REQ-007 valid  output  1: one-cycle pulse when measure_out updates.
REQ-008 locked  output  1: high while the two most recent measurements are equal.
REQ-009 overflow  output  1: sticky flag; half-period exceeded the counter range.

Function
REQ-010 sig_in SHALL pass through SYNC_STAGES flip-flops, then a 1-cycle delay register; edge = synced XOR delayed, so both polarities count as edges.
REQ-011 Edge detection latency SHALL be SYNC_STAGES+1 cycles from the sig_in transition.
REQ-012 Counter cnt (WIDTH bits) SHALL load 0 on an edge cycle and increment by 1 on every other cycle.
REQ-013 With edges at cycles t and t+N+1, cnt SHALL equal N at the second edge; on that edge measure_out <= cnt, giving round-trip identity with divider load N.
REQ-014 FSM states: IDLE (no reference edge yet) and MEASURE.
REQ-015 IDLE + edge: cnt <= 0, go MEASURE, no valid, measure_out unchanged.
REQ-016 MEASURE + edge: measure_out <= cnt, valid <= 1, overflow <= 0, cnt <= 0, stay MEASURE.
REQ-017 On every measurement, locked <= 1 iff new cnt equals current measure_out and a previous measurement exists since the last IDLE; otherwise locked <= 0.
REQ-018 MEASURE, no edge, cnt all-ones: overflow <= 1, locked <= 0, go IDLE; cnt holds all-ones (no wrap).
REQ-019 In IDLE without an edge, cnt SHALL hold its value; no outputs change.
REQ-020 N = 0 (edge every cycle) SHALL yield measure_out = 0 and valid high every cycle.
REQ-021 Edge in the same cycle cnt reaches all-ones: the edge wins (REQ-016); no overflow.
REQ-022 valid SHALL be low in every cycle not covered by REQ-016.

Reset
REQ-023 rst high SHALL force state IDLE, cnt 0, measure_out 0, valid 0, locked 0, overflow 0, and all synchronizer and delay flops 0; reset takes priority over all events.
REQ-024 Reset asserted mid-measurement SHALL discard the partial count; the first edge after release only re-arms (IDLE), with no valid.
REQ-025 A sig_in high at reset release SHALL produce one edge after synchronization; this edge counts as a normal re-arm edge.

Structure
REQ-026 No shared package required; WIDTH and SYNC_STAGES are the only parameters.
REQ-027 One sub-module, sync_edge_det (synchronizer, delay flop, edge output), parameterized by SYNC_STAGES and reusable elsewhere.
REQ-028 The FSM, counter and output registers SHALL reside in half_period_meter; all outputs are registered.

Verification
REQ-029 Drive sig_in from a divider with load 5 -> valid every 6 cycles, measure_out = 5, locked high from the second measurement on.
REQ-030 Divider load 0 -> measure_out = 0, valid high every cycle after re-arm, locked high.
REQ-031 Switch load from 5 to 9 mid-stream -> one measurement of 9 with locked = 0, then locked = 1 on the next measurement.
REQ-032 WIDTH = 4, sig_in held constant after one edge -> overflow = 1 and state IDLE after 16 cycles; next two edges -> valid, overflow cleared.
REQ-033 Assert rst for 1 cycle mid half-period -> all outputs 0; first post-reset edge gives no valid, second gives a correct measure_out.
REQ-034 Edge arriving in the same cycle cnt = all-ones (WIDTH = 4, N = 15) -> valid with measure_out = 15, overflow stays 0.
